// File: rtl/flag_branch_unit_pkg.sv
// -----------------------------------------------------------------------------
// flag_branch_unit_pkg
//   Shared definitions for the flag/branch unit:
//     - ALU opcode encoding (identical to the 16-bit ALU's encoding)
//     - branch condition-code encoding
//     - branch FSM state encoding
//     - flag_writes(op): {N,Z,V} write mask for an ALU opcode
//   Flag vectors throughout this slice are packed as {N, Z, V}.
// -----------------------------------------------------------------------------
package flag_branch_unit_pkg;

  localparam int ALU_OP_W = 3;
  localparam int COND_W   = 3;
  localparam int FLAG_W   = 3;

  // Bit positions inside a packed {N,Z,V} flag vector.
  localparam int FLAG_N_IDX = 2;
  localparam int FLAG_Z_IDX = 1;
  localparam int FLAG_V_IDX = 0;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_RED    = 3'b011,
    OP_SLL    = 3'b100,
    OP_SRA    = 3'b101,
    OP_ROR    = 3'b110,
    OP_PADDSB = 3'b111
  } alu_op_e;

  typedef enum logic [COND_W-1:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_AL = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Which architectural flags an opcode is allowed to update, as {N,Z,V}.
  // Arithmetic ops own all three flags, logic/shift ops only touch Z, and
  // the reduction/saturating ops leave the flag register alone.
  function automatic logic [FLAG_W-1:0] flag_writes(input logic [ALU_OP_W-1:0] op);
    logic [FLAG_W-1:0] mask;
    mask = '0;
    case (op)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b010;
      default:                        mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// -----------------------------------------------------------------------------
// flag_branch_unit_if
//   Branch request/response channel between decode/fetch and the flag/branch
//   unit.
//     br_valid   decode presents a branch
//     br_cond    condition code of that branch
//     br_ready   unit accepts the branch this cycle (br_valid && br_ready)
//     resp_valid registered resolution pulse (held while the pipe is stalled)
//     resp_taken resolution, meaningful only with resp_valid
//   Modports:
//     master - decode/fetch side (drives the request, sees the response)
//     slave  - flag_branch_unit side
// -----------------------------------------------------------------------------
interface flag_branch_unit_if;
  import flag_branch_unit_pkg::*;

  logic              br_valid;
  logic [COND_W-1:0] br_cond;
  logic              br_ready;
  logic              resp_valid;
  logic              resp_taken;

  modport master (
    output br_valid,
    output br_cond,
    input  br_ready,
    input  resp_valid,
    input  resp_taken
  );

  modport slave (
    input  br_valid,
    input  br_cond,
    output br_ready,
    output resp_valid,
    output resp_taken
  );

endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
//   Purely combinational condition evaluator: flags + condition code -> taken.
//   Ports:
//     flag_n, flag_z, flag_v  flag values to evaluate against
//     cond                    condition code (cond_e encoding)
//     taken                   1 when the branch condition holds
// -----------------------------------------------------------------------------
module branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic              flag_n,
  input  logic              flag_z,
  input  logic              flag_v,
  input  logic [COND_W-1:0] cond,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE: taken = !flag_z;
      COND_EQ: taken = flag_z;
      COND_GT: taken = !flag_z && !flag_n;
      COND_LT: taken = flag_n;
      COND_GE: taken = flag_z || !flag_n;
      COND_LE: taken = flag_n || flag_z;
      COND_OV: taken = flag_v;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//   Owns the architectural N/Z/V flag register fed by the EX-stage ALU and
//   resolves conditional branches from decode against it, returning a
//   registered taken/not-taken response to fetch.
//
//   Parameters:
//     FWD_EN  1: same-cycle EX flags are forwarded into branch evaluation
//             0: a branch meeting a flag-writing op in EX waits one cycle
//                (HOLD) and is evaluated against the registered flags
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     ex_valid, ex_aluop        ALU instruction in EX and its opcode
//     ex_ovfl, ex_zero, ex_sign ALU result flags
//     stall                     pipeline hold: no flag write, FSM frozen
//     flush                     squash in-flight branch request/response
//     br                        branch request/response channel (slave)
//     flag_n, flag_z, flag_v    architectural flag register
// -----------------------------------------------------------------------------
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [ALU_OP_W-1:0] ex_aluop,
  input  logic                ex_ovfl,
  input  logic                ex_zero,
  input  logic                ex_sign,
  input  logic                stall,
  input  logic                flush,
  flag_branch_unit_if.slave   br,
  output logic                flag_n,
  output logic                flag_z,
  output logic                flag_v
);

  // ---------------------------------------------------------------------------
  // Flag register
  // ---------------------------------------------------------------------------
  logic [FLAG_W-1:0] flags_reg;
  logic [FLAG_W-1:0] flags_next;
  logic [FLAG_W-1:0] ex_flags;
  logic [FLAG_W-1:0] wr_mask;
  logic              ex_writes;

  assign ex_flags  = {ex_sign, ex_zero, ex_ovfl};
  assign wr_mask   = ex_valid ? flag_writes(ex_aluop) : '0;
  // A flag-writing op is present in EX; decides the HOLD path when FWD_EN=0.
  assign ex_writes = |wr_mask;

  genvar gi;
  generate
    for (gi = 0; gi < FLAG_W; gi++) begin : g_flag_next
      assign flags_next[gi] = wr_mask[gi] ? ex_flags[gi] : flags_reg[gi];
    end
  endgenerate

  // flush deliberately does not gate this: the EX op is older than any
  // branch being squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_reg <= '0;
    end else if (!stall) begin
      flags_reg <= flags_next;
    end
  end

  assign flag_n = flags_reg[FLAG_N_IDX];
  assign flag_z = flags_reg[FLAG_Z_IDX];
  assign flag_v = flags_reg[FLAG_V_IDX];

  // ---------------------------------------------------------------------------
  // Effective flags for a branch accepted this cycle
  // ---------------------------------------------------------------------------
  logic [FLAG_W-1:0] eff_flags;

  generate
    if (FWD_EN) begin : g_fwd
      assign eff_flags = flags_next;
    end else begin : g_no_fwd
      // Without forwarding an accept only evaluates directly when nothing in
      // EX writes flags, so the registered value is already current.
      assign eff_flags = flags_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Branch FSM
  // ---------------------------------------------------------------------------
  state_e            state_reg;
  logic [COND_W-1:0] cond_reg;
  logic              resp_valid_reg;
  logic              resp_taken_reg;

  logic              accept;
  logic              defer;
  logic [FLAG_W-1:0] eval_flags;
  logic [COND_W-1:0] eval_cond;
  logic              eval_taken;

  assign br.br_ready = (state_reg == ST_IDLE) && !stall && !flush && !rst;
  assign accept      = br.br_valid && br.br_ready;
  assign defer       = !FWD_EN && ex_writes;

  // One evaluator serves both the direct path (IDLE) and the deferred path
  // (HOLD, latched cond against the freshly registered flags).
  assign eval_flags = (state_reg == ST_HOLD) ? flags_reg : eff_flags;
  assign eval_cond  = (state_reg == ST_HOLD) ? cond_reg  : br.br_cond;

  branch_cond_eval u_cond_eval (
    .flag_n (eval_flags[FLAG_N_IDX]),
    .flag_z (eval_flags[FLAG_Z_IDX]),
    .flag_v (eval_flags[FLAG_V_IDX]),
    .cond   (eval_cond),
    .taken  (eval_taken)
  );

  // Priority: rst > flush > stall. While stalled in RESP the pulse simply
  // stays asserted; the consumer qualifies it with !stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cond_reg       <= '0;
      resp_valid_reg <= 1'b0;
      resp_taken_reg <= 1'b0;
    end else if (flush) begin
      state_reg      <= ST_IDLE;
      resp_valid_reg <= 1'b0;
    end else if (!stall) begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (defer) begin
              cond_reg  <= br.br_cond;
              state_reg <= ST_HOLD;
            end else begin
              resp_taken_reg <= eval_taken;
              resp_valid_reg <= 1'b1;
              state_reg      <= ST_RESP;
            end
          end
        end
        ST_HOLD: begin
          resp_taken_reg <= eval_taken;
          resp_valid_reg <= 1'b1;
          state_reg      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  assign br.resp_valid = resp_valid_reg;
  assign br.resp_taken = resp_taken_reg;

endmodule
